// File: rtl/len_arbiter.sv
// ============================================================================
// len_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares a single N-bit logic element array (len) between two requesters.
//   Each requester offers an operation (mode m, select s, operands a/b) on a
//   valid/ready handshake. One requester is granted (round-robin on a tie),
//   its operation is registered onto the array inputs, the array result is
//   captured one cycle later, and the result is returned with the issuing
//   requester's id on a response handshake.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (0 or 1)
//   reqN_m, reqN_s            mode bit and 2-bit function select
//   reqN_a, reqN_b            N-bit operands
//   len_m, len_s, len_a, len_b  registered operation driven to the array
//   len_x                     combinational array result
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that issued the returned result
//   rsp_x                     registered array result
//   busy                      high whenever an operation is in flight
// ============================================================================
module len_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_m,
    input  logic [1:0]   req0_s,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_m,
    input  logic [1:0]   req1_s,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,

    output logic         len_m,
    output logic [1:0]   len_s,
    output logic [N-1:0] len_a,
    output logic [N-1:0] len_b,
    input  logic [N-1:0] len_x,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_x,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           id_q, id_d;
    logic           len_m_q, len_m_d;
    logic [1:0]     len_s_q, len_s_d;
    logic [N-1:0]   len_a_q, len_a_d;
    logic [N-1:0]   len_b_q, len_b_d;
    logic [N-1:0]   rsp_x_q, rsp_x_d;

    logic           grant_any;
    logic           grant_id;

    // On a tie the priority pointer picks the winner; otherwise whichever
    // requester is valid wins. grant_id is only meaningful with grant_any.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;

    // Next-state and handshake logic. The array inputs, id and priority only
    // move on a grant, so the array is never re-driven between operations.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        id_d       = id_q;
        len_m_d    = len_m_q;
        len_s_d    = len_s_q;
        len_a_d    = len_a_q;
        len_b_d    = len_b_q;
        rsp_x_d    = rsp_x_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    id_d       = grant_id;
                    // The loser of this grant wins the next tie.
                    prio_d     = ~grant_id;
                    len_m_d    = grant_id ? req1_m : req0_m;
                    len_s_d    = grant_id ? req1_s : req0_s;
                    len_a_d    = grant_id ? req1_a : req0_a;
                    len_b_d    = grant_id ? req1_b : req0_b;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Array inputs have been stable for this whole cycle.
                rsp_x_d = len_x;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any operation still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            len_m_q <= 1'b0;
            len_s_q <= 2'b00;
            len_a_q <= '0;
            len_b_q <= '0;
            rsp_x_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            len_m_q <= len_m_d;
            len_s_q <= len_s_d;
            len_a_q <= len_a_d;
            len_b_q <= len_b_d;
            rsp_x_q <= rsp_x_d;
        end
    end

    assign len_m     = len_m_q;
    assign len_s     = len_s_q;
    assign len_a     = len_a_q;
    assign len_b     = len_b_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_id    = id_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_len_arbiter.sv
// ============================================================================
// tb_len_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for len_arbiter. The array is stubbed as
//   len_x = len_a ^ len_b. Expected responses are queued when an operation
//   is issued and popped by a monitor when the DUT hands a result over.
// ============================================================================
module tb_len_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req0_m;
    logic [1:0]   req0_s;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_m;
    logic [1:0]   req1_s;
    logic [N-1:0] req1_a, req1_b;
    logic         len_m;
    logic [1:0]   len_s;
    logic [N-1:0] len_a, len_b, len_x;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_x;
    logic         busy;

    len_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_m     (req0_m),
        .req0_s     (req0_s),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_m     (req1_m),
        .req1_s     (req1_s),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .len_m      (len_m),
        .len_s      (len_s),
        .len_a      (len_a),
        .len_b      (len_b),
        .len_x      (len_x),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_x      (rsp_x),
        .busy       (busy)
    );

    // Array stub
    assign len_x = len_a ^ len_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic       v1;
        logic       m0;
        logic [1:0] s0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       m1;
        logic [1:0] s1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       first;
        logic [7:0] x0;
        logic [7:0] x1;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] x;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    int compares = 0;
    int fails    = 0;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a result handed over must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                checkOutput("rsp_x", 32'(rsp_x), 32'(mon_e.x));
            end
        end
    end

    // Ready must be one-hot-or-zero and never asserted while busy.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("ready_legal",
                        32'((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready))),
                        32'(0));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic resetDut();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_len_m"}, 32'(len_m), 32'(0));
        checkOutput({tag, "_len_s"}, 32'(len_s), 32'(0));
        checkOutput({tag, "_len_a"}, 32'(len_a), 32'(0));
        checkOutput({tag, "_len_b"}, 32'(len_b), 32'(0));
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
        checkOutput({tag, "_rsp_x"}, 32'(rsp_x), 32'(0));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_req0_ready"}, 32'(req0_ready), 32'(0));
        checkOutput({tag, "_req1_ready"}, 32'(req1_ready), 32'(0));
    endtask

    // Wait until every queued expectation has been handed back.
    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drain_timeout"}, 32'(sb.size()), 32'(0));
    endtask

    // Drive one table vector: queue expectations in the predicted grant
    // order, hold each valid until accepted, then wait for all responses.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        logic p0, p1, acc0, acc1;
        int   n;
        if (v.v0 && v.v1) begin
            e.id = v.first;
            e.x  = v.first ? v.x1 : v.x0;
            sb.push_back(e);
            e.id = ~v.first;
            e.x  = v.first ? v.x0 : v.x1;
            sb.push_back(e);
        end else begin
            e.id = v.v1;
            e.x  = v.v1 ? v.x1 : v.x0;
            sb.push_back(e);
        end
        req0_m = v.m0; req0_s = v.s0; req0_a = v.a0; req0_b = v.b0;
        req1_m = v.m1; req1_s = v.s1; req1_a = v.a1; req1_b = v.b1;
        req0_valid = v.v0;
        req1_valid = v.v1;
        p0 = v.v0;
        p1 = v.v1;
        n  = 0;
        while ((p0 || p1) && n < 40) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) begin req0_valid = 1'b0; p0 = 1'b0; end
            if (acc1) begin req1_valid = 1'b0; p1 = 1'b0; end
            n++;
        end
        checkOutput({tag, "_accept_timeout"}, 32'(p0 || p1), 32'(0));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDrain(tag);
    endtask

    // Issue a single request and return once it is accepted.
    task automatic driveOne(input logic id, input logic [7:0] a, input logic [7:0] b,
                            input logic push, input string tag);
        exp_t e;
        logic acc;
        int   n;
        if (id) begin
            req1_m = 1'b0; req1_s = 2'b00; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_m = 1'b0; req0_s = 2'b00; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = id ? req1_ready : req0_ready;
            if (acc && push) begin
                e.id = id;
                e.x  = a ^ b;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        checkOutput({tag, "_accept_timeout"}, 32'(acc), 32'(1));
    endtask

    task automatic waitRspValid(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_rsp_valid_timeout"}, 32'(rsp_valid), 32'(1));
    endtask

    initial begin
        exp_t       e;
        logic       g0, g1;
        logic [7:0] fa0, fb0, fa1, fb1;
        int         grants, last, n;

        rst = 1'b1;
        req0_valid = 1'b0; req0_m = 1'b0; req0_s = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_m = 1'b0; req1_s = 2'b00; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b0;

        //          v0    v1    m0    s0     a0     b0     m1    s1     a1     b1     first x0     x1
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h01, 8'h00, 1'b0, 2'b00, 8'h02, 8'h00, 1'b0, 8'h01, 8'h02};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'b01, 8'h3C, 8'hFF, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'hC3, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 8'h80, 8'h01, 1'b1, 8'h00, 8'h81};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 8'h55, 8'h55, 1'b1, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b10, 8'hFF, 8'h00, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b0, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b11, 8'h12, 8'h34, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h26, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b00, 8'hAA, 8'hAA, 1'b1, 2'b10, 8'h0F, 8'hF0, 1'b1, 8'h00, 8'hFF};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b01, 8'h11, 8'h22, 1'b0, 2'b11, 8'h44, 8'h88, 1'b1, 8'h33, 8'hCC};

        $display("[TB] reset values");
        resetDut();
        checkResetValues("reset");

        $display("[TB] single operation timing");
        rsp_ready  = 1'b1;
        e.id = 1'b0;
        e.x  = 8'hAA;
        sb.push_back(e);
        req0_m = 1'b1; req0_s = 2'b01; req0_a = 8'hA5; req0_b = 8'h0F;
        req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("single_req0_ready", 32'(req0_ready), 32'(1));
        checkOutput("single_req1_ready", 32'(req1_ready), 32'(0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        checkOutput("single_len_m", 32'(len_m), 32'(1));
        checkOutput("single_len_s", 32'(len_s), 32'(1));
        checkOutput("single_len_a", 32'(len_a), 32'(8'hA5));
        checkOutput("single_len_b", 32'(len_b), 32'(8'h0F));
        checkOutput("single_exec_busy", 32'(busy), 32'(1));
        checkOutput("single_exec_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("single_exec_req0_ready", 32'(req0_ready), 32'(0));
        @(posedge clk);
        #1;
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'(1));
        checkOutput("single_rsp_id", 32'(rsp_id), 32'(0));
        checkOutput("single_rsp_x", 32'(rsp_x), 32'(8'hAA));
        @(posedge clk);
        #1;
        checkOutput("single_done_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("single_done_busy", 32'(busy), 32'(0));
        checkOutput("single_len_hold", 32'(len_a), 32'(8'hA5));
        waitDrain("single");

        $display("[TB] table vectors");
        resetDut();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] fairness");
        resetDut();
        rsp_ready = 1'b1;
        fa0 = 8'h10; fb0 = 8'h01; fa1 = 8'h20; fb1 = 8'h02;
        req0_m = 1'b0; req0_s = 2'b00; req0_a = fa0; req0_b = fb0;
        req1_m = 1'b1; req1_s = 2'b11; req1_a = fa1; req1_b = fb1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        grants = 0;
        last   = 0;
        n      = 0;
        while (grants < 6 && n < 60) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            if (g0 || g1) begin
                checkOutput($sformatf("fair_grant%0d_id", grants), 32'(g1), 32'(grants % 2));
                if (grants > 0) begin
                    checkOutput($sformatf("fair_grant%0d_interval", grants), 32'(n - last), 32'(3));
                end
                e.id = g1;
                e.x  = g1 ? (fa1 ^ fb1) : (fa0 ^ fb0);
                sb.push_back(e);
                last = n;
                grants++;
            end
            @(posedge clk);
            #1;
            n++;
            if (g0) begin fa0 = fa0 + 8'h01; req0_a = fa0; end
            if (g1) begin fa1 = fa1 + 8'h01; req1_a = fa1; end
            if (grants == 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("fair_grant_count", 32'(grants), 32'(6));
        waitDrain("fair");

        $display("[TB] back-pressure");
        resetDut();
        rsp_ready = 1'b0;
        driveOne(1'b0, 8'h5A, 8'h0F, 1'b1, "bp_req0");
        req1_m = 1'b0; req1_s = 2'b00; req1_a = 8'h77; req1_b = 8'h07;
        req1_valid = 1'b1;
        waitRspValid("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_rsp_valid", k), 32'(rsp_valid), 32'(1));
            checkOutput($sformatf("bp_hold%0d_rsp_x", k), 32'(rsp_x), 32'(8'h55));
            checkOutput($sformatf("bp_hold%0d_rsp_id", k), 32'(rsp_id), 32'(0));
            checkOutput($sformatf("bp_hold%0d_req1_ready", k), 32'(req1_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        e.id = 1'b1;
        e.x  = 8'h70;
        sb.push_back(e);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_handshake_req1_ready", 32'(req1_ready), 32'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_req1_accept_next", 32'(req1_ready), 32'(1));
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        waitDrain("bp");

        $display("[TB] reset during response");
        resetDut();
        rsp_ready = 1'b0;
        driveOne(1'b0, 8'hF0, 8'h0F, 1'b0, "rst_mid");
        waitRspValid("rst_mid");
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkResetValues("rst_mid");
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_after_busy", 32'(busy), 32'(0));
        checkOutput("rst_mid_after_rsp_valid", 32'(rsp_valid), 32'(0));
        @(posedge clk);
        #1;
        // A tie right after reset must go to requester 0.
        applyStimulus(vecs[0], "rst_mid_prio");

        checkOutput("sb_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
